// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: writeback requests, reservations and regfile write port of the write arbiter
interface regfile_write_arbiter_if #(parameter int NUM_REQ = 2);
  logic [NUM_REQ-1:0] req_valid;
  logic [3*NUM_REQ-1:0] req_dest;
  logic [16*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0] req_ready;
  logic rsv_valid;
  logic [2:0] rsv_reg;
  logic rsv_ready;
  logic rf_load;
  logic [2:0] rf_dest;
  logic [15:0] rf_in;
  logic [7:0] busy;
  logic [1:0] grant_id;
  logic err_underflow;
  modport master (
    output req_valid, req_dest, req_data, rsv_valid, rsv_reg,
    input req_ready, rsv_ready, rf_load, rf_dest, rf_in, busy, grant_id, err_underflow
  );
  modport slave (
    input req_valid, req_dest, req_data, rsv_valid, rsv_reg,
    output req_ready, rsv_ready, rf_load, rf_dest, rf_in, busy, grant_id, err_underflow
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin share of the regfile write port plus pending-write scoreboard; REGFILE_WRITE_ARBITER_FIXED_PRIO_EN selects fixed priority
module regfile_write_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int CNT_W = 2
) (
  input logic clk,
  input logic reset_n,
  regfile_write_arbiter_if.slave bus
);
  logic [1:0] start, g, g_lo, g_hi, grant_id;
  logic hit_lo, hit_hi, xfer, rsv_ok, rf_load, err;
  logic [NUM_REQ-1:0] ready;
  logic [2:0] sel_dest, rf_dest;
  logic [15:0] sel_data, rf_in;
  logic [7:0] inc, dec, busy;
  logic [CNT_W-1:0] pend_cnt [8];
`ifdef REGFILE_WRITE_ARBITER_FIXED_PRIO_EN
  assign start = 2'd0;
`else
  logic [1:0] rr_ptr;
  assign start = rr_ptr;
  // move the search start just past the requester that was served
  always_ff @(posedge clk)
    if (!reset_n) rr_ptr <= 2'd0;
    else if (xfer) rr_ptr <= (int'(g) == NUM_REQ - 1) ? 2'd0 : g + 2'd1;
`endif
  // first valid requester at or after start, else wrap to the lowest valid one
  always_comb begin
    g_lo = 2'd0;
    g_hi = 2'd0;
    hit_lo = 1'b0;
    hit_hi = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        g_lo = 2'(i);
        hit_lo = 1'b1;
      end
      if (bus.req_valid[i] && 2'(i) >= start) begin
        g_hi = 2'(i);
        hit_hi = 1'b1;
      end
    end
    g = hit_hi ? g_hi : g_lo;
    ready = '0;
    sel_dest = 3'd0;
    sel_data = 16'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ready[i] = reset_n && hit_lo && g == 2'(i);
      if (g == 2'(i)) begin
        sel_dest = bus.req_dest[3*i +: 3];
        sel_data = bus.req_data[16*i +: 16];
      end
    end
  end
  assign xfer = |ready;
  assign rsv_ok = reset_n && bus.rsv_valid && pend_cnt[bus.rsv_reg] != '1;
  // registered write stage: dest/data/grant hold when idle
  always_ff @(posedge clk)
    if (!reset_n) begin
      rf_load <= 1'b0;
      rf_dest <= 3'd0;
      rf_in <= 16'd0;
      grant_id <= 2'd0;
    end else begin
      rf_load <= xfer;
      if (xfer) begin
        rf_dest <= sel_dest;
        rf_in <= sel_data;
        grant_id <= g;
      end
    end
  // per-register reservation/commit strobes and busy flags
  always_comb begin
    inc = '0;
    dec = '0;
    busy = '0;
    for (int r = 0; r < 8; r++) begin
      inc[r] = rsv_ok && bus.rsv_reg == 3'(r);
      dec[r] = rf_load && rf_dest == 3'(r);
      busy[r] = pend_cnt[r] != '0;
    end
  end
  // pending-write counters; a commit against an empty counter latches the underflow flag
  always_ff @(posedge clk)
    if (!reset_n) begin
      for (int r = 0; r < 8; r++) pend_cnt[r] <= '0;
      err <= 1'b0;
    end else
      for (int r = 0; r < 8; r++)
        if (inc[r] && !dec[r]) pend_cnt[r] <= pend_cnt[r] + CNT_W'(1);
        else if (dec[r] && !inc[r]) begin
          if (pend_cnt[r] != '0) pend_cnt[r] <= pend_cnt[r] - CNT_W'(1);
          else err <= 1'b1;
        end
  assign bus.req_ready = ready;
  assign bus.rsv_ready = rsv_ok;
  assign bus.rf_load = rf_load;
  assign bus.rf_dest = rf_dest;
  assign bus.rf_in = rf_in;
  assign bus.busy = busy;
  assign bus.grant_id = grant_id;
  assign bus.err_underflow = err;
endmodule
